serial_code_lock: RTL and testbench
===================================

// Module: serial_code_lock
// PURPOSE
//  Parametrised serial combination lock. Code bits arrive one per qualified clock, MSB first,
//  and are checked against a stored code of CODE_LEN bits. Adds a valid qualifier, a wrong-attempt
//  counter with timed lockout, an auto-relock timer and in-field code reprogramming while unlocked.
//  Sits between the keypad/bit-serialiser front end and the door-actuator/status logic.
// PARAMETERS
//  CODE_LEN      10               code length in bits (>=2)
//  DEFAULT_CODE  10'b0000001101   code loaded at reset (CODE_LEN bits)
//  MAX_FAIL      3                wrong attempts before lockout (>=1)
//  LOCKOUT_CYC   16               clocks spent in LOCKOUT (>=1)
//  UNLOCK_CYC    8                clocks unlock is held before auto-relock; 0 = hold until relock
// PORTS
//  clk       in   1                   clock, rising edge
//  rst_n     in   1                   asynchronous reset, active low
//  x_valid   in   1                   x is a code bit this cycle
//  x         in   1                   serial code bit
//  relock    in   1                   force return to locked state (level, sampled per clk)
//  prog_en   in   1                   request code programming (honoured only in UNLOCKED)
//  unlock    out  1                   lock open
//  vg        out  1                   one-cycle pulse: accepted bit was correct / stored
//  ng        out  1                   one-cycle pulse: accepted bit was wrong
//  lockout   out  1                   lockout active, input ignored
//  fail_cnt  out  $clog2(MAX_FAIL+1)  wrong attempts since last success/lockout
//  bit_idx   out  $clog2(CODE_LEN)    index of next expected bit (0 = MSB)
// BEHAVIOUR
//  - Reset (async, rst_n=0): state ENTER, code<=DEFAULT_CODE, bit_idx=0, fail_cnt=0, timers=0,
//    unlock=vg=ng=lockout=0. Reset mid-entry/programming discards partial input; any
//    partially programmed code is dropped and DEFAULT_CODE is restored.
//  - All outputs are registered; response appears the clock after the qualifying x_valid edge.
//  - States: ENTER, UNLOCKED, PROGRAM, LOCKOUT. Cycles with x_valid=0 change nothing in ENTER/PROGRAM.
//  - ENTER: on x_valid, compare x to code[CODE_LEN-1-bit_idx].
//      match, bit_idx<CODE_LEN-1: vg pulse, bit_idx+1.
//      match, bit_idx==CODE_LEN-1: vg pulse, bit_idx<=0, fail_cnt<=0, ->UNLOCKED, unlock<=1.
//      mismatch: ng pulse, bit_idx<=0, fail_cnt+1; if new fail_cnt==MAX_FAIL -> LOCKOUT,
//      lockout<=1. A mismatched bit never starts a new attempt (no overlap search).
//  - UNLOCKED: unlock=1. Priority: relock > prog_en > timeout. relock -> ENTER, unlock<=0.
//    prog_en -> PROGRAM (unlock stays 1, timer stopped). If UNLOCK_CYC>0, after UNLOCK_CYC
//    clocks in UNLOCKED -> ENTER, unlock<=0. x_valid ignored (no vg/ng).
//  - PROGRAM: each x_valid bit shifts into a shadow register MSB first, vg pulse, bit_idx+1.
//    After CODE_LEN-th bit: code<=shadow atomically, bit_idx<=0, unlock<=0, ->ENTER.
//    relock during PROGRAM aborts: shadow discarded, code unchanged, ->ENTER, unlock<=0.
//    Simultaneous relock and final bit: relock wins, code unchanged.
//  - LOCKOUT: lockout=1, x_valid/relock/prog_en ignored, no vg/ng. After LOCKOUT_CYC clocks:
//    ->ENTER, lockout<=0, fail_cnt<=0, bit_idx<=0.
//  - vg and ng never asserted together; unlock and lockout never asserted together.
//  - fail_cnt saturates at MAX_FAIL; bit_idx wraps only via explicit reset to 0 above.
// TESTING
//  1 Defaults; after reset feed 0000001101 with x_valid=1 -> 10 vg pulses, unlock=1 on cycle
//    after 10th bit, fail_cnt=0.
//  2 Feed 1 as first bit -> ng pulse, bit_idx=0, fail_cnt=1; repeat twice more -> lockout=1
//    for exactly 16 clocks, bits ignored, then lockout=0, fail_cnt=0.
//  3 Correct code with x_valid gaps (valid every 3rd clock) -> unlock; UNLOCK_CYC=8 -> unlock
//    drops after 8 clocks; with UNLOCK_CYC=0 holds until relock=1.
//  4 Unlock, prog_en=1, shift 1010101010 -> 10 vg, unlock=0, state ENTER; old code now gives
//    ng on 1st bit (0 vs 1), 1010101010 unlocks.
//  5 PROGRAM with relock on 10th bit -> code still 0000001101; rst_n pulse mid-entry after
//    5 good bits -> bit_idx=0, all outputs 0 asynchronously.
//  6 CODE_LEN=4, DEFAULT_CODE=4'b1001, MAX_FAIL=1 -> 1001 unlocks; single wrong bit -> lockout.

Source files
------------

// File: rtl/serial_code_lock_if.sv
// Interface: serial_code_lock_if
// Bundles the serial-code front-end handshake with the lock status outputs.
//   x_valid  : x carries a code bit this cycle
//   x        : serial code bit, MSB first
//   relock   : force return to the locked state (level)
//   prog_en  : request code programming (honoured only while unlocked)
//   unlock   : lock open
//   vg / ng  : one-cycle pulse, accepted bit correct (or stored) / wrong
//   lockout  : lockout active, input ignored
//   fail_cnt : wrong attempts since last success/lockout
//   bit_idx  : index of next expected bit (0 = MSB)
// Modports: slave = lock core, master = front end / bench.
interface serial_code_lock_if #(
    parameter int unsigned CODE_LEN = 10,
    parameter int unsigned MAX_FAIL = 3
);
    localparam int unsigned IDX_W  = $clog2(CODE_LEN);
    localparam int unsigned FAIL_W = $clog2(MAX_FAIL + 1);

    logic              x_valid;
    logic              x;
    logic              relock;
    logic              prog_en;
    logic              unlock;
    logic              vg;
    logic              ng;
    logic              lockout;
    logic [FAIL_W-1:0] fail_cnt;
    logic [IDX_W-1:0]  bit_idx;

    modport master (
        output x_valid, x, relock, prog_en,
        input  unlock, vg, ng, lockout, fail_cnt, bit_idx
    );

    modport slave (
        input  x_valid, x, relock, prog_en,
        output unlock, vg, ng, lockout, fail_cnt, bit_idx
    );
endinterface

// File: rtl/serial_code_lock.sv
// Module: serial_code_lock
// Serial combination lock: code bits arrive MSB first on qualified clocks and are
// compared against a stored CODE_LEN-bit code. Wrong attempts are counted and lead
// to a timed lockout; a successful entry opens the lock, which relocks on request
// or after UNLOCK_CYC clocks (0 = never). While open, the code can be reprogrammed.
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous reset, active low
//   bus    : serial_code_lock_if slave (inputs x_valid/x/relock/prog_en,
//            registered outputs unlock/vg/ng/lockout/fail_cnt/bit_idx)
module serial_code_lock #(
    parameter int unsigned         CODE_LEN     = 10,
    parameter logic [CODE_LEN-1:0] DEFAULT_CODE = 10'b0000001101,
    parameter int unsigned         MAX_FAIL     = 3,
    parameter int unsigned         LOCKOUT_CYC  = 16,
    parameter int unsigned         UNLOCK_CYC   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    serial_code_lock_if.slave bus
);
    localparam int unsigned IDX_W   = $clog2(CODE_LEN);
    localparam int unsigned FAIL_W  = $clog2(MAX_FAIL + 1);
    localparam int unsigned TMR_MAX = (LOCKOUT_CYC > UNLOCK_CYC) ? LOCKOUT_CYC : UNLOCK_CYC;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [IDX_W-1:0]  IDX_LAST    = IDX_W'(CODE_LEN - 1);
    localparam logic [FAIL_W-1:0] FAIL_MAX    = FAIL_W'(MAX_FAIL);
    localparam logic [TMR_W-1:0]  LOCK_LAST   = TMR_W'(LOCKOUT_CYC - 1);
    localparam logic [TMR_W-1:0]  OPEN_LAST   = TMR_W'((UNLOCK_CYC == 0) ? 0 : UNLOCK_CYC - 1);
    localparam bit                AUTO_RELOCK = (UNLOCK_CYC != 0);

    typedef enum logic [1:0] {
        ST_ENTER    = 2'd0,
        ST_UNLOCKED = 2'd1,
        ST_PROGRAM  = 2'd2,
        ST_LOCKOUT  = 2'd3
    } state_e;

    state_e              state_q,    state_d;
    logic [CODE_LEN-1:0] code_q,     code_d;
    logic [CODE_LEN-1:0] shadow_q,   shadow_d;
    logic [IDX_W-1:0]    bit_idx_q,  bit_idx_d;
    logic [FAIL_W-1:0]   fail_cnt_q, fail_cnt_d;
    logic [TMR_W-1:0]    timer_q,    timer_d;
    logic                unlock_q,   unlock_d;
    logic                lockout_q,  lockout_d;
    logic                vg_q,       vg_d;
    logic                ng_q,       ng_d;

    logic                exp_bit_c;
    logic [FAIL_W-1:0]   fail_inc_c;
    logic [CODE_LEN-1:0] shadow_next_c;

    // Expected code bit for the current position, MSB first.
    assign exp_bit_c     = code_q[IDX_LAST - bit_idx_q];
    // Saturating wrong-attempt increment.
    assign fail_inc_c    = (fail_cnt_q == FAIL_MAX) ? fail_cnt_q : fail_cnt_q + FAIL_W'(1);
    // Programming shift: new bit enters at the LSB so the first bit ends up as MSB.
    assign shadow_next_c = {shadow_q[CODE_LEN-2:0], bus.x};

    // Next-state and output decode.
    always_comb begin
        state_d    = state_q;
        code_d     = code_q;
        shadow_d   = shadow_q;
        bit_idx_d  = bit_idx_q;
        fail_cnt_d = fail_cnt_q;
        timer_d    = timer_q;
        unlock_d   = unlock_q;
        lockout_d  = lockout_q;
        vg_d       = 1'b0;
        ng_d       = 1'b0;

        case (state_q)
            ST_ENTER: begin
                if (bus.x_valid) begin
                    if (bus.x == exp_bit_c) begin
                        vg_d = 1'b1;
                        if (bit_idx_q == IDX_LAST) begin
                            bit_idx_d  = '0;
                            fail_cnt_d = '0;
                            timer_d    = '0;
                            unlock_d   = 1'b1;
                            state_d    = ST_UNLOCKED;
                        end else begin
                            bit_idx_d = bit_idx_q + IDX_W'(1);
                        end
                    end else begin
                        // A wrong bit aborts the attempt; it never starts a new one.
                        ng_d       = 1'b1;
                        bit_idx_d  = '0;
                        fail_cnt_d = fail_inc_c;
                        if (fail_inc_c == FAIL_MAX) begin
                            timer_d   = '0;
                            lockout_d = 1'b1;
                            state_d   = ST_LOCKOUT;
                        end
                    end
                end
            end

            ST_UNLOCKED: begin
                // relock beats prog_en beats the auto-relock timeout.
                if (bus.relock) begin
                    unlock_d = 1'b0;
                    state_d  = ST_ENTER;
                end else if (bus.prog_en) begin
                    shadow_d  = '0;
                    bit_idx_d = '0;
                    state_d   = ST_PROGRAM;
                end else if (AUTO_RELOCK && (timer_q == OPEN_LAST)) begin
                    unlock_d = 1'b0;
                    state_d  = ST_ENTER;
                end else if (AUTO_RELOCK) begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end

            ST_PROGRAM: begin
                if (bus.relock) begin
                    // Abort: the partially shifted code never reaches code_q.
                    shadow_d  = '0;
                    bit_idx_d = '0;
                    unlock_d  = 1'b0;
                    state_d   = ST_ENTER;
                end else if (bus.x_valid) begin
                    vg_d     = 1'b1;
                    shadow_d = shadow_next_c;
                    if (bit_idx_q == IDX_LAST) begin
                        code_d    = shadow_next_c;
                        bit_idx_d = '0;
                        unlock_d  = 1'b0;
                        state_d   = ST_ENTER;
                    end else begin
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                    end
                end
            end

            ST_LOCKOUT: begin
                if (timer_q == LOCK_LAST) begin
                    lockout_d  = 1'b0;
                    fail_cnt_d = '0;
                    bit_idx_d  = '0;
                    state_d    = ST_ENTER;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end

            default: begin
                state_d = ST_ENTER;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_ENTER;
            code_q     <= DEFAULT_CODE;
            shadow_q   <= '0;
            bit_idx_q  <= '0;
            fail_cnt_q <= '0;
            timer_q    <= '0;
            unlock_q   <= 1'b0;
            lockout_q  <= 1'b0;
            vg_q       <= 1'b0;
            ng_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            code_q     <= code_d;
            shadow_q   <= shadow_d;
            bit_idx_q  <= bit_idx_d;
            fail_cnt_q <= fail_cnt_d;
            timer_q    <= timer_d;
            unlock_q   <= unlock_d;
            lockout_q  <= lockout_d;
            vg_q       <= vg_d;
            ng_q       <= ng_d;
        end
    end

    assign bus.unlock   = unlock_q;
    assign bus.lockout  = lockout_q;
    assign bus.vg       = vg_q;
    assign bus.ng       = ng_q;
    assign bus.fail_cnt = fail_cnt_q;
    assign bus.bit_idx  = bit_idx_q;
endmodule

// File: tb/tb_serial_code_lock.sv
// Testbench: tb_serial_code_lock
// Three lock instances checked every cycle against a rule-level model:
//   dut 0: defaults (10-bit code, MAX_FAIL 3, auto-relock after 8 clocks)
//   dut 1: defaults but UNLOCK_CYC 0 (hold until relock)
//   dut 2: CODE_LEN 4, DEFAULT_CODE 1001, MAX_FAIL 1
module tb_serial_code_lock;
    localparam int M_ENTER = 0;
    localparam int M_OPEN  = 1;
    localparam int M_PROG  = 2;
    localparam int M_LOCK  = 3;

    localparam int C_LEN  [3] = '{10, 10, 4};
    localparam int C_DFLT [3] = '{13, 13, 9};
    localparam int C_MAXF [3] = '{3, 3, 1};
    localparam int C_LKC  [3] = '{16, 16, 16};
    localparam int C_ULC  [3] = '{8, 0, 8};

    typedef struct {
        int mode;
        int code;
        int shadow;
        int idx;
        int fails;
        int tmr;
        bit unlock;
        bit vg;
        bit ng;
        bit lockout;
    } mdl_t;

    logic clk = 1'b0;
    logic rst_n;
    logic [2:0] xv, xb, rl, pe;
    logic [2:0] o_unl, o_vg, o_ng, o_lock;
    logic [2:0][3:0] o_idx, o_fail;

    int n_vec;
    int n_err;
    int vg_seen [3];
    int ng_seen [3];
    mdl_t mdl [3];

    always #5 clk = ~clk;

    serial_code_lock_if #(.CODE_LEN(10), .MAX_FAIL(3)) ifa ();
    serial_code_lock_if #(.CODE_LEN(10), .MAX_FAIL(3)) ifb ();
    serial_code_lock_if #(.CODE_LEN(4),  .MAX_FAIL(1)) ifc ();

    assign ifa.x_valid = xv[0]; assign ifa.x = xb[0]; assign ifa.relock = rl[0]; assign ifa.prog_en = pe[0];
    assign ifb.x_valid = xv[1]; assign ifb.x = xb[1]; assign ifb.relock = rl[1]; assign ifb.prog_en = pe[1];
    assign ifc.x_valid = xv[2]; assign ifc.x = xb[2]; assign ifc.relock = rl[2]; assign ifc.prog_en = pe[2];

    assign o_unl  = {ifc.unlock,  ifb.unlock,  ifa.unlock};
    assign o_vg   = {ifc.vg,      ifb.vg,      ifa.vg};
    assign o_ng   = {ifc.ng,      ifb.ng,      ifa.ng};
    assign o_lock = {ifc.lockout, ifb.lockout, ifa.lockout};
    assign o_idx[0]  = 4'(ifa.bit_idx);
    assign o_idx[1]  = 4'(ifb.bit_idx);
    assign o_idx[2]  = 4'(ifc.bit_idx);
    assign o_fail[0] = 4'(ifa.fail_cnt);
    assign o_fail[1] = 4'(ifb.fail_cnt);
    assign o_fail[2] = 4'(ifc.fail_cnt);

    serial_code_lock #(
        .CODE_LEN(10), .DEFAULT_CODE(10'b0000001101), .MAX_FAIL(3),
        .LOCKOUT_CYC(16), .UNLOCK_CYC(8)
    ) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));

    serial_code_lock #(
        .CODE_LEN(10), .DEFAULT_CODE(10'b0000001101), .MAX_FAIL(3),
        .LOCKOUT_CYC(16), .UNLOCK_CYC(0)
    ) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

    serial_code_lock #(
        .CODE_LEN(4), .DEFAULT_CODE(4'b1001), .MAX_FAIL(1),
        .LOCKOUT_CYC(16), .UNLOCK_CYC(8)
    ) dut_c (.clk(clk), .rst_n(rst_n), .bus(ifc));

    function automatic mdl_t mdl_reset(input int d);
        mdl_t s;
        s.mode = M_ENTER; s.code = C_DFLT[d]; s.shadow = 0; s.idx = 0;
        s.fails = 0; s.tmr = 0; s.unlock = 0; s.vg = 0; s.ng = 0; s.lockout = 0;
        return s;
    endfunction

    // One clock of the lock rules, in terms of counts of elapsed clocks and attempt position.
    function automatic mdl_t mdl_step(input int d, input mdl_t s, input bit v, input bit b,
                                      input bit r, input bit p);
        mdl_t n = s;
        int len = C_LEN[d];
        n.vg = 0;
        n.ng = 0;
        case (s.mode)
            M_ENTER: if (v) begin
                if (int'(b) == ((s.code >> (len - 1 - s.idx)) & 1)) begin
                    n.vg = 1;
                    n.idx = s.idx + 1;
                    if (n.idx == len) begin
                        n.idx = 0; n.fails = 0; n.mode = M_OPEN; n.unlock = 1; n.tmr = 0;
                    end
                end else begin
                    n.ng = 1;
                    n.idx = 0;
                    n.fails = (s.fails < C_MAXF[d]) ? s.fails + 1 : s.fails;
                    if (n.fails == C_MAXF[d]) begin
                        n.mode = M_LOCK; n.lockout = 1; n.tmr = 0;
                    end
                end
            end
            M_OPEN: begin
                if (r) begin
                    n.mode = M_ENTER; n.unlock = 0;
                end else if (p) begin
                    n.mode = M_PROG; n.shadow = 0; n.idx = 0;
                end else if (C_ULC[d] > 0) begin
                    n.tmr = s.tmr + 1;
                    if (n.tmr == C_ULC[d]) begin
                        n.mode = M_ENTER; n.unlock = 0;
                    end
                end
            end
            M_PROG: begin
                if (r) begin
                    n.mode = M_ENTER; n.unlock = 0; n.idx = 0; n.shadow = 0;
                end else if (v) begin
                    n.vg = 1;
                    n.shadow = ((s.shadow << 1) | int'(b)) & ((1 << len) - 1);
                    n.idx = s.idx + 1;
                    if (n.idx == len) begin
                        n.code = n.shadow; n.idx = 0; n.unlock = 0; n.mode = M_ENTER;
                    end
                end
            end
            default: begin
                n.tmr = s.tmr + 1;
                if (n.tmr == C_LKC[d]) begin
                    n.mode = M_ENTER; n.lockout = 0; n.fails = 0; n.idx = 0;
                end
            end
        endcase
        return n;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model advances on the same edges as the DUTs.
    always @(posedge clk or negedge rst_n) begin
        for (int d = 0; d < 3; d++) begin
            if (!rst_n) mdl[d] = mdl_reset(d);
            else        mdl[d] = mdl_step(d, mdl[d], xv[d], xb[d], rl[d], pe[d]);
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            check($sformatf("dut%0d unlock", d),   int'(o_unl[d]),  int'(mdl[d].unlock));
            check($sformatf("dut%0d vg", d),       int'(o_vg[d]),   int'(mdl[d].vg));
            check($sformatf("dut%0d ng", d),       int'(o_ng[d]),   int'(mdl[d].ng));
            check($sformatf("dut%0d lockout", d),  int'(o_lock[d]), int'(mdl[d].lockout));
            check($sformatf("dut%0d fail_cnt", d), int'(o_fail[d]), mdl[d].fails);
            check($sformatf("dut%0d bit_idx", d),  int'(o_idx[d]),  mdl[d].idx);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input int d, input bit b);
        xv[d] = 1'b1;
        xb[d] = b;
        tick();
        xv[d] = 1'b0;
        vg_seen[d] += int'(o_vg[d]);
        ng_seen[d] += int'(o_ng[d]);
    endtask

    task automatic send_code(input int d, input int code, input int len, input int gap);
        for (int i = len - 1; i >= 0; i--) begin
            repeat (gap) tick();
            send_bit(d, 1'(code >> i));
        end
    endtask

    task automatic pulse_relock(input int d);
        rl[d] = 1'b1; tick(); rl[d] = 1'b0;
    endtask

    task automatic pulse_prog(input int d);
        pe[d] = 1'b1; tick(); pe[d] = 1'b0;
    endtask

    // Clocks for which unlock (which=0) or lockout (which=1) stays high, feeding junk bits.
    task automatic count_high(input int d, input int which, output int cnt, output int junk);
        cnt = 0;
        junk = 0;
        while (((which == 0) ? o_unl[d] : o_lock[d]) && cnt < 100) begin
            xv[d] = 1'b1;
            xb[d] = 1'(cnt);
            tick();
            cnt++;
            junk += int'(o_vg[d]) + int'(o_ng[d]);
        end
        xv[d] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cnt;
        int junk;
        n_vec = 0;
        n_err = 0;
        xv = '0; xb = '0; rl = '0; pe = '0;
        for (int d = 0; d < 3; d++) begin
            vg_seen[d] = 0;
            ng_seen[d] = 0;
        end
        rst_n = 1'b0;
        repeat (3) tick();
        for (int d = 0; d < 3; d++) begin
            check($sformatf("reset dut%0d unlock", d), int'(o_unl[d]), 0);
            check($sformatf("reset dut%0d bit_idx", d), int'(o_idx[d]), 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Default code opens the lock; auto-relock after 8 clocks.
        send_code(0, 13, 10, 0);
        check("t1 vg pulses", vg_seen[0], 10);
        check("t1 unlock", int'(o_unl[0]), 1);
        check("t1 fail_cnt", int'(o_fail[0]), 0);
        count_high(0, 0, cnt, junk);
        check("t3 unlock hold clocks", cnt, 8);
        check("t3 ignored bits while open", junk, 0);

        // Three wrong first bits lead to a 16-clock lockout.
        send_bit(0, 1'b1);
        check("t2 ng pulse", int'(o_ng[0]), 1);
        check("t2 bit_idx", int'(o_idx[0]), 0);
        check("t2 fail_cnt", int'(o_fail[0]), 1);
        send_bit(0, 1'b1);
        send_bit(0, 1'b1);
        check("t2 lockout", int'(o_lock[0]), 1);
        check("t2 fail_cnt max", int'(o_fail[0]), 3);
        count_high(0, 1, cnt, junk);
        check("t2 lockout clocks", cnt, 16);
        check("t2 ignored bits in lockout", junk, 0);
        check("t2 fail_cnt cleared", int'(o_fail[0]), 0);

        // Gapped entry, then reprogram to 1010101010.
        send_code(0, 13, 10, 2);
        check("t3 gapped unlock", int'(o_unl[0]), 1);
        pulse_prog(0);
        check("t4 unlock in program", int'(o_unl[0]), 1);
        vg_seen[0] = 0;
        send_code(0, 682, 10, 0);
        check("t4 program vg pulses", vg_seen[0], 10);
        check("t4 unlock after program", int'(o_unl[0]), 0);
        send_bit(0, 1'b0);
        check("t4 old code ng", int'(o_ng[0]), 1);
        send_code(0, 682, 10, 0);
        check("t4 new code unlock", int'(o_unl[0]), 1);
        pulse_relock(0);
        check("t4 relock", int'(o_unl[0]), 0);

        // UNLOCK_CYC=0 holds; relock on the final programming bit wins.
        send_code(1, 13, 10, 0);
        repeat (20) tick();
        check("t3 hold without timeout", int'(o_unl[1]), 1);
        pulse_prog(1);
        repeat (9) send_bit(1, 1'b1);
        rl[1] = 1'b1;
        send_bit(1, 1'b1);
        rl[1] = 1'b0;
        check("t5 abort unlock", int'(o_unl[1]), 0);
        check("t5 abort bit_idx", int'(o_idx[1]), 0);
        send_code(1, 13, 10, 0);
        check("t5 code unchanged", int'(o_unl[1]), 1);
        pulse_relock(1);

        // Asynchronous reset in the middle of an entry.
        repeat (5) send_bit(1, 1'b0);
        check("t5 partial bit_idx", int'(o_idx[1]), 5);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5 async bit_idx", int'(o_idx[1]), 0);
        check("t5 async vg", int'(o_vg[1]), 0);
        check("t5 async unlock", int'(o_unl[1]), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Short code, single-fail lockout.
        send_code(2, 9, 4, 0);
        check("t6 unlock", int'(o_unl[2]), 1);
        pulse_relock(2);
        send_bit(2, 1'b0);
        check("t6 ng", int'(o_ng[2]), 1);
        check("t6 lockout", int'(o_lock[2]), 1);
        check("t6 fail_cnt", int'(o_fail[2]), 1);
        count_high(2, 1, cnt, junk);
        check("t6 lockout clocks", cnt, 16);
        send_code(2, 9, 4, 0);
        check("t6 unlock after lockout", int'(o_unl[2]), 1);

        repeat (3) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
